windowed_intensity_correlator: RTL and testbench
================================================

# windowed_intensity_correlator

Synchronous, parametrised multi-lag photon-coincidence correlator for two single-bit detector channels. Each channel is synchronised, then optionally edge-detected, then fed into a MAX_DELAY-tap delay line. Every cycle, each lag bin counts coincidences between opposing taps. Counts accumulate over a programmable integration window, then are snapshotted into a readout bank for the host/readout logic while the next window integrates.

## Interface
- MAX_DELAY, 64: number of lag bins and depth of each delay line (≥2).
- RESOLUTION, 32: bin counter width in bits.
- WINDOW_W, 32: width of window-length input.
- SYNC_STAGES, 2: synchroniser flops per input (≥2).
- ADDR_W, $clog2(MAX_DELAY): readout address width.

- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low; clears all state.
- in1, in2  in  1  asynchronous detector inputs.
- edge_mode  in  1  0 = count level coincidences each cycle, 1 = count only rising-edge pulses; sampled at start.
- continuous  in  1  1 = restart a new window automatically; sampled at start.
- window_len  in  WINDOW_W  integration length in cycles (0 treated as 1); sampled at start.
- start  in  1  one-cycle pulse; begins acquisition from IDLE.
- stop  in  1  one-cycle pulse; aborts acquisition.
- rd_addr  in  ADDR_W  snapshot bin select.
- rd_data  out  RESOLUTION  snapshot bin value, registered.
- busy  out  1  high in any state other than IDLE.
- frame_valid  out  1  one-cycle pulse when a new snapshot is committed.
- frame_overflow  out  1  at least one bin saturated in the last committed frame.
- frame_count  out  16  committed frames since reset, wraps.

## Operation
- Front end: SYNC_STAGES-flop synchroniser per input gives s1/s2. In edge_mode, p = s & ~s_prev; otherwise p = s.
- Delay lines: tap1[0]=p1, tap1[k]=tap1[k-1] delayed 1 cycle; tap2 likewise. Both shift continuously, including in IDLE.
- Bin i hit = tap1[i] & tap2[MAX_DELAY-1-i]. Relative lag of bin i = 2i-(MAX_DELAY-1) cycles.
- Accumulators: one RESOLUTION-bit counter per bin. On a hit in INTEGRATE, the counter increments. It saturates at 2^RESOLUTION-1 and sets that bin's sticky sat flag.
- FSM:
  - IDLE: accumulators, sat flags and window counter held at 0. start → FILL and latch mode, continuous and window_len.
  - FILL: MAX_DELAY-1 cycles, no counting, so taps hold post-start data → INTEGRATE.
  - INTEGRATE: count for window_len cycles. On the last cycle, snapshot bank ← accumulator + that cycle's hit (saturated). frame_overflow ← OR of sat flags, including that cycle's saturation. Pulse frame_valid, increment frame_count. Accumulators and sat flags clear for the next cycle. Then:
    - continuous=1: stay in INTEGRATE, no refill, no dead cycle.
    - continuous=0: → IDLE.
  - stop in FILL/INTEGRATE → IDLE. Partial window is discarded; snapshot bank, frame_overflow and frame_count are unchanged.
  - stop and the last window cycle coinciding: the snapshot commits, then → IDLE.
  - start while busy: ignored.
- Snapshot bank holds the last committed frame until the next commit. Readout is legal any time, including during integration.

## Timing
- Reset values: rd_data 0, busy 0, frame_valid 0, frame_overflow 0, frame_count 0, snapshot bank all 0, FSM IDLE.
- rd_data = bank[rd_addr] one cycle after rd_addr is presented. Out-of-range addresses return 0.
- busy rises the cycle after start is sampled.
- First frame_valid: MAX_DELAY-1 + window_len cycles after the busy-rise cycle.
- In continuous mode, consecutive frame_valid pulses are exactly window_len cycles apart.
- A bank read in the frame_valid cycle returns the new frame one cycle later.
- Input-to-tap latency: SYNC_STAGES cycles for level mode, same for edge mode (s_prev is compared, no extra stage).
- Reset deassertion mid-acquisition: next posedge sees IDLE; no frame_valid is emitted.

## Test plan
- Level mode, MAX_DELAY=8, window_len=100, in1=in2=1 constant, single-shot → one frame_valid. Every bin = 100, busy falls, frame_overflow=0.
- Edge mode, single pulse on in2 then on in1 3 cycles later, repeated every 20 cycles for 200 cycles → only the bin with 2i-7=+3 or −3 per defined sign is nonzero, = 10. All others 0.
- RESOLUTION=4, level mode, both high, window_len=40 → all bins = 15, frame_overflow=1. Next continuous frame with inputs low → all bins 0, frame_overflow=0.
- Continuous, window_len=50 → frame_valid spacing exactly 50. frame_count increments 1,2,3. stop asserted mid-window → no further pulse, bank holds last frame.
- Async reset asserted mid-INTEGRATE → all outputs 0 immediately. After release, start → normal first frame at MAX_DELAY-1+window_len.
- Readout sweep of rd_addr 0..MAX_DELAY-1 during integration → returns prior snapshot values with 1-cycle latency, unchanged until the next frame_valid.

Source files
------------

// File: rtl/windowed_intensity_correlator.sv
// Multi-lag coincidence correlator: synchronised detector inputs feed two tap lines,
// per-lag saturating counters integrate over a window and commit into a readout bank.
module windowed_intensity_correlator #(
  parameter int MAX_DELAY   = 64,
  parameter int RESOLUTION  = 32,
  parameter int WINDOW_W    = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = $clog2(MAX_DELAY)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in1,
  input  logic                  in2,
  input  logic                  edge_mode,
  input  logic                  continuous,
  input  logic [WINDOW_W-1:0]   window_len,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [RESOLUTION-1:0] rd_data,
  output logic                  busy,
  output logic                  frame_valid,
  output logic                  frame_overflow,
  output logic [15:0]           frame_count
);

  localparam int FILL_W = $clog2(MAX_DELAY);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_INTEGRATE} state_e;
  typedef logic [RESOLUTION-1:0] cnt_t;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic                   prev1_q, prev1_d, prev2_q, prev2_d;
  logic                   s1, s2, p1, p2;
  logic [MAX_DELAY-1:0]   tap1, tap2, hit;
  logic [MAX_DELAY-2:0]   dl1_q, dl1_d, dl2_q, dl2_d;
  logic                   edge_q, edge_d, cont_q, cont_d;
  logic [WINDOW_W-1:0]    wlen_q, wlen_d, win_cnt_q, win_cnt_d;
  logic [FILL_W-1:0]      fill_cnt_q, fill_cnt_d;
  cnt_t                   acc_q [MAX_DELAY];
  cnt_t                   acc_d [MAX_DELAY];
  cnt_t                   acc_nx [MAX_DELAY];
  cnt_t                   bank_q [MAX_DELAY];
  cnt_t                   bank_d [MAX_DELAY];
  logic [MAX_DELAY-1:0]   sat_q, sat_d, sat_nx;
  logic                   last_cycle;
  logic                   frame_valid_q, frame_valid_d;
  logic                   frame_ovf_q, frame_ovf_d;
  logic [15:0]            frame_count_q, frame_count_d;
  cnt_t                   rd_data_q, rd_data_d;

  always_comb begin : front_end
    sync1_d = {sync1_q[SYNC_STAGES-2:0], in1};
    sync2_d = {sync2_q[SYNC_STAGES-2:0], in2};
    s1      = sync1_q[SYNC_STAGES-1];
    s2      = sync2_q[SYNC_STAGES-1];
    prev1_d = s1;
    prev2_d = s2;
    // Edge pulse compares against the previous synchroniser output, adding no latency.
    p1      = edge_q ? (s1 & ~prev1_q) : s1;
    p2      = edge_q ? (s2 & ~prev2_q) : s2;
    tap1    = {dl1_q, p1};
    tap2    = {dl2_q, p2};
    dl1_d   = tap1[MAX_DELAY-2:0];
    dl2_d   = tap2[MAX_DELAY-2:0];
    hit     = '0;
    for (int unsigned i = 0; i < MAX_DELAY; i++) begin
      hit[i] = tap1[i] & tap2[MAX_DELAY-1-i];
    end
  end

  always_comb begin : bin_update
    sat_nx = sat_q;
    for (int unsigned i = 0; i < MAX_DELAY; i++) begin
      if (hit[i] && (acc_q[i] == '1)) begin
        acc_nx[i] = acc_q[i];
        sat_nx[i] = 1'b1;
      end else begin
        acc_nx[i] = acc_q[i] + cnt_t'(hit[i]);
      end
    end
  end

  assign last_cycle = (win_cnt_q == (wlen_q - WINDOW_W'(1)));

  always_comb begin : control
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    win_cnt_d     = win_cnt_q;
    wlen_d        = wlen_q;
    edge_d        = edge_q;
    cont_d        = cont_q;
    acc_d         = acc_q;
    sat_d         = sat_q;
    bank_d        = bank_q;
    frame_valid_d = 1'b0;
    frame_ovf_d   = frame_ovf_q;
    frame_count_d = frame_count_q;
    case (state_q)
      ST_IDLE: begin
        acc_d      = '{default: '0};
        sat_d      = '0;
        win_cnt_d  = '0;
        fill_cnt_d = '0;
        if (start) begin
          state_d = ST_FILL;
          edge_d  = edge_mode;
          cont_d  = continuous;
          wlen_d  = (window_len == '0) ? WINDOW_W'(1) : window_len;
        end
      end
      ST_FILL: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (fill_cnt_q == FILL_W'(MAX_DELAY - 2)) begin
          state_d    = ST_INTEGRATE;
          fill_cnt_d = '0;
        end else begin
          fill_cnt_d = fill_cnt_q + FILL_W'(1);
        end
      end
      ST_INTEGRATE: begin
        acc_d     = acc_nx;
        sat_d     = sat_nx;
        win_cnt_d = win_cnt_q + WINDOW_W'(1);
        if (last_cycle) begin
          // Commit wins over a coincident stop; the bank includes this cycle's hits.
          bank_d        = acc_nx;
          frame_ovf_d   = |sat_nx;
          frame_valid_d = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          acc_d         = '{default: '0};
          sat_d         = '0;
          win_cnt_d     = '0;
          state_d       = (cont_q && !stop) ? ST_INTEGRATE : ST_IDLE;
        end else if (stop) begin
          acc_d     = '{default: '0};
          sat_d     = '0;
          win_cnt_d = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : readout
    rd_data_d = '0;
    for (int unsigned i = 0; i < MAX_DELAY; i++) begin
      if (32'(rd_addr) == i) rd_data_d = bank_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev1_q       <= 1'b0;
      prev2_q       <= 1'b0;
      dl1_q         <= '0;
      dl2_q         <= '0;
      edge_q        <= 1'b0;
      cont_q        <= 1'b0;
      wlen_q        <= WINDOW_W'(1);
      win_cnt_q     <= '0;
      fill_cnt_q    <= '0;
      acc_q         <= '{default: '0};
      sat_q         <= '0;
      bank_q        <= '{default: '0};
      frame_valid_q <= 1'b0;
      frame_ovf_q   <= 1'b0;
      frame_count_q <= '0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev1_q       <= prev1_d;
      prev2_q       <= prev2_d;
      dl1_q         <= dl1_d;
      dl2_q         <= dl2_d;
      edge_q        <= edge_d;
      cont_q        <= cont_d;
      wlen_q        <= wlen_d;
      win_cnt_q     <= win_cnt_d;
      fill_cnt_q    <= fill_cnt_d;
      acc_q         <= acc_d;
      sat_q         <= sat_d;
      bank_q        <= bank_d;
      frame_valid_q <= frame_valid_d;
      frame_ovf_q   <= frame_ovf_d;
      frame_count_q <= frame_count_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign rd_data        = rd_data_q;
  assign busy           = (state_q != ST_IDLE);
  assign frame_valid    = frame_valid_q;
  assign frame_overflow = frame_ovf_q;
  assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_windowed_intensity_correlator.sv
// Directed bench for windowed_intensity_correlator: a 16-bit-bin instance and a
// 4-bit-bin instance with a wide address share all stimulus.
module tb_windowed_intensity_correlator;
  localparam int MD = 8;

  logic        clk = 1'b0, reset = 1'b0;
  logic        in1 = 1'b0, in2 = 1'b0, edge_mode = 1'b0, continuous = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [15:0] window_len = '0;
  logic [3:0]  rd_addr = '0;
  logic [15:0] rd_data, frame_count, frame_count_s;
  logic [3:0]  rd_data_s;
  logic        busy, frame_valid, frame_overflow;
  logic        busy_s, frame_valid_s, frame_overflow_s;
  int          vec = 0, miss = 0, cyc = 0;

  windowed_intensity_correlator #(.MAX_DELAY(MD), .RESOLUTION(16), .WINDOW_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2), .edge_mode(edge_mode),
    .continuous(continuous), .window_len(window_len), .start(start), .stop(stop),
    .rd_addr(rd_addr[2:0]), .rd_data(rd_data), .busy(busy), .frame_valid(frame_valid),
    .frame_overflow(frame_overflow), .frame_count(frame_count));

  windowed_intensity_correlator #(.MAX_DELAY(MD), .RESOLUTION(4), .WINDOW_W(16), .SYNC_STAGES(2), .ADDR_W(4)) dut_s (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2), .edge_mode(edge_mode),
    .continuous(continuous), .window_len(window_len), .start(start), .stop(stop),
    .rd_addr(rd_addr), .rd_data(rd_data_s), .busy(busy_s), .frame_valid(frame_valid_s),
    .frame_overflow(frame_overflow_s), .frame_count(frame_count_s));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_start(output int t0);
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_fv(input int budget, input string name);
    int n = 0;
    while (frame_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (frame_valid !== 1'b1) begin
      vec++; miss++;
      $display("FAIL %s: no frame_valid within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    vec++; if (rd_data !== 16'd0) begin miss++; $display("FAIL rst_rd_data: got %0d want 0", rd_data); end
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL rst_busy: got %b want 0", busy); end
    vec++; if (frame_valid !== 1'b0) begin miss++; $display("FAIL rst_fv: got %b want 0", frame_valid); end
    vec++; if (frame_overflow !== 1'b0) begin miss++; $display("FAIL rst_ovf: got %b want 0", frame_overflow); end
    vec++; if (frame_count !== 16'd0) begin miss++; $display("FAIL rst_fc: got %0d want 0", frame_count); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_level_single();
    int t0;
    in1 = 1'b1; in2 = 1'b1; edge_mode = 1'b0; continuous = 1'b0; window_len = 16'd100;
    repeat (12) tick();
    pulse_start(t0);
    vec++; if (busy !== 1'b1) begin miss++; $display("FAIL t1_busy_rise: got %b want 1", busy); end
    wait_fv(200, "t1_fv");
    vec++; if (cyc - t0 != 107) begin miss++; $display("FAIL t1_latency: got %0d want 107", cyc - t0); end
    vec++; if (frame_valid_s !== 1'b1) begin miss++; $display("FAIL t1_fv_s: got %b want 1", frame_valid_s); end
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL t1_busy_fall: got %b want 0", busy); end
    vec++; if (frame_count !== 16'd1) begin miss++; $display("FAIL t1_fc: got %0d want 1", frame_count); end
    vec++; if (frame_overflow !== 1'b0) begin miss++; $display("FAIL t1_ovf: got %b want 0", frame_overflow); end
    vec++; if (frame_overflow_s !== 1'b1) begin miss++; $display("FAIL t1_ovf_s: got %b want 1", frame_overflow_s); end
    for (int i = 0; i < MD; i++) begin
      rd_addr = 4'(i);
      tick();
      if (i == 0) begin
        vec++; if (frame_valid !== 1'b0) begin miss++; $display("FAIL t1_fv_width: got %b want 0", frame_valid); end
      end
      vec++; if (rd_data !== 16'd100) begin miss++; $display("FAIL t1_bin%0d: got %0d want 100", i, rd_data); end
      vec++; if (rd_data_s !== 4'd15) begin miss++; $display("FAIL t1_sbin%0d: got %0d want 15", i, rd_data_s); end
    end
    rd_addr = 4'd9;  tick();
    vec++; if (rd_data_s !== 4'd0) begin miss++; $display("FAIL t1_oob9: got %0d want 0", rd_data_s); end
    rd_addr = 4'd15; tick();
    vec++; if (rd_data_s !== 4'd0) begin miss++; $display("FAIL t1_oob15: got %0d want 0", rd_data_s); end
  endtask

  task automatic test_edge_mode();
    int t0, rel, fv_at;
    logic [15:0] exp;
    in1 = 1'b0; in2 = 1'b0;
    repeat (12) tick();
    edge_mode = 1'b1; continuous = 1'b0; window_len = 16'd200;
    pulse_start(t0);
    fv_at = -1;
    for (int c = 0; c < 220; c++) begin
      rel = cyc - t0;
      in2 = (rel >= 10 && rel < 200 && ((rel - 10) % 20) < 3);
      in1 = (rel >= 13 && rel < 203 && ((rel - 13) % 20) < 3);
      tick();
      if (frame_valid === 1'b1 && fv_at < 0) fv_at = cyc - t0;
    end
    vec++; if (fv_at != 207) begin miss++; $display("FAIL t2_latency: got %0d want 207", fv_at); end
    vec++; if (frame_count !== 16'd2) begin miss++; $display("FAIL t2_fc: got %0d want 2", frame_count); end
    for (int i = 0; i < MD; i++) begin
      exp = (i == 2) ? 16'd10 : 16'd0;
      rd_addr = 4'(i);
      tick();
      vec++; if (rd_data !== exp) begin miss++; $display("FAIL t2_bin%0d: got %0d want %0d", i, rd_data, exp); end
      vec++; if (rd_data_s !== exp[3:0]) begin miss++; $display("FAIL t2_sbin%0d: got %0d want %0d", i, rd_data_s, exp); end
    end
    edge_mode = 1'b0;
  endtask

  task automatic test_saturation();
    int t0, f1, m;
    in1 = 1'b1; in2 = 1'b1; continuous = 1'b1; window_len = 16'd40;
    repeat (12) tick();
    pulse_start(t0);
    while (cyc - t0 < 27) tick();
    in1 = 1'b0; in2 = 1'b0;
    wait_fv(100, "t3_fv1");
    f1 = cyc;
    vec++; if (f1 - t0 != 47) begin miss++; $display("FAIL t3_latency: got %0d want 47", f1 - t0); end
    vec++; if (frame_overflow_s !== 1'b1) begin miss++; $display("FAIL t3_ovf_s1: got %b want 1", frame_overflow_s); end
    vec++; if (frame_overflow !== 1'b0) begin miss++; $display("FAIL t3_ovf1: got %b want 0", frame_overflow); end
    for (int i = 0; i < MD; i++) begin
      m = (i < MD - 1 - i) ? i : MD - 1 - i;
      rd_addr = 4'(i);
      tick();
      vec++; if (rd_data_s !== 4'd15) begin miss++; $display("FAIL t3_sbin%0d: got %0d want 15", i, rd_data_s); end
      vec++; if (rd_data !== 16'(22 + m)) begin miss++; $display("FAIL t3_bin%0d: got %0d want %0d", i, rd_data, 22 + m); end
    end
    wait_fv(100, "t3_fv2");
    vec++; if (cyc - f1 != 40) begin miss++; $display("FAIL t3_spacing: got %0d want 40", cyc - f1); end
    vec++; if (frame_overflow_s !== 1'b0) begin miss++; $display("FAIL t3_ovf_s2: got %b want 0", frame_overflow_s); end
    vec++; if (frame_count !== 16'd4) begin miss++; $display("FAIL t3_fc: got %0d want 4", frame_count); end
    for (int i = 0; i < MD; i++) begin
      rd_addr = 4'(i);
      tick();
      vec++; if (rd_data_s !== 4'd0) begin miss++; $display("FAIL t3_zsbin%0d: got %0d want 0", i, rd_data_s); end
      vec++; if (rd_data !== 16'd0) begin miss++; $display("FAIL t3_zbin%0d: got %0d want 0", i, rd_data); end
    end
    stop = 1'b1; tick(); stop = 1'b0;
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL t3_stop_busy: got %b want 0", busy); end
  endtask

  task automatic test_continuous_stop();
    int t0, fp, extra;
    in1 = 1'b1; in2 = 1'b1; continuous = 1'b1; window_len = 16'd50;
    repeat (12) tick();
    pulse_start(t0);
    wait_fv(100, "t4_fv1");
    vec++; if (cyc - t0 != 57) begin miss++; $display("FAIL t4_latency: got %0d want 57", cyc - t0); end
    vec++; if (frame_count !== 16'd5) begin miss++; $display("FAIL t4_fc1: got %0d want 5", frame_count); end
    fp = cyc;
    tick();
    for (int k = 2; k <= 3; k++) begin
      wait_fv(100, "t4_fvn");
      vec++; if (cyc - fp != 50) begin miss++; $display("FAIL t4_spacing%0d: got %0d want 50", k, cyc - fp); end
      vec++; if (frame_count !== 16'(4 + k)) begin miss++; $display("FAIL t4_fc%0d: got %0d want %0d", k, frame_count, 4 + k); end
      fp = cyc;
      if (k != 3) tick();
    end
    in1 = 1'b0; in2 = 1'b0;
    while (cyc < fp + 20) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL t4_stop_busy: got %b want 0", busy); end
    extra = 0;
    repeat (100) begin
      tick();
      if (frame_valid === 1'b1) extra++;
    end
    vec++; if (extra != 0) begin miss++; $display("FAIL t4_no_pulse: got %0d pulses want 0", extra); end
    vec++; if (frame_count !== 16'd7) begin miss++; $display("FAIL t4_fc_hold: got %0d want 7", frame_count); end
    vec++; if (frame_overflow_s !== 1'b1) begin miss++; $display("FAIL t4_ovf_s_hold: got %b want 1", frame_overflow_s); end
    for (int i = 0; i < MD; i++) begin
      rd_addr = 4'(i);
      tick();
      vec++; if (rd_data !== 16'd50) begin miss++; $display("FAIL t4_bin%0d: got %0d want 50", i, rd_data); end
    end
  endtask

  task automatic test_async_reset();
    int t0;
    in1 = 1'b1; in2 = 1'b1; continuous = 1'b1; window_len = 16'd30; rd_addr = 4'd0;
    repeat (12) tick();
    pulse_start(t0);
    while (cyc - t0 < 20) tick();
    vec++; if (rd_data !== 16'd50) begin miss++; $display("FAIL t5_pre_rd: got %0d want 50", rd_data); end
    #1 reset = 1'b0;
    #1;
    vec++; if (rd_data !== 16'd0) begin miss++; $display("FAIL t5_rd: got %0d want 0", rd_data); end
    vec++; if (busy !== 1'b0 || busy_s !== 1'b0) begin miss++; $display("FAIL t5_busy: got %b/%b want 0/0", busy, busy_s); end
    vec++; if (frame_count !== 16'd0 || frame_count_s !== 16'd0) begin miss++; $display("FAIL t5_fc: got %0d/%0d want 0/0", frame_count, frame_count_s); end
    vec++; if (frame_overflow_s !== 1'b0) begin miss++; $display("FAIL t5_ovf_s: got %b want 0", frame_overflow_s); end
    vec++; if (frame_valid !== 1'b0) begin miss++; $display("FAIL t5_fv: got %b want 0", frame_valid); end
    tick();
    reset = 1'b1;
    repeat (5) tick();
    vec++; if (busy !== 1'b0 || frame_valid !== 1'b0) begin miss++; $display("FAIL t5_post: got busy=%b fv=%b want 0,0", busy, frame_valid); end
    continuous = 1'b0;
    pulse_start(t0);
    wait_fv(100, "t5_fv");
    vec++; if (cyc - t0 != 37) begin miss++; $display("FAIL t5_latency: got %0d want 37", cyc - t0); end
    vec++; if (frame_count !== 16'd1) begin miss++; $display("FAIL t5_fc1: got %0d want 1", frame_count); end
    for (int i = 0; i < MD; i++) begin
      rd_addr = 4'(i);
      tick();
      vec++; if (rd_data !== 16'd30) begin miss++; $display("FAIL t5_bin%0d: got %0d want 30", i, rd_data); end
    end
  endtask

  task automatic test_readout_during_integration();
    int t0, f1;
    in1 = 1'b1; in2 = 1'b1; continuous = 1'b1; window_len = 16'd60;
    pulse_start(t0);
    wait_fv(200, "t6_fv1");
    f1 = cyc;
    in2 = 1'b0;
    vec++; if (f1 - t0 != 67) begin miss++; $display("FAIL t6_latency: got %0d want 67", f1 - t0); end
    vec++; if (frame_count !== 16'd2) begin miss++; $display("FAIL t6_fc1: got %0d want 2", frame_count); end
    for (int i = 0; i < MD; i++) begin
      rd_addr = 4'(i);
      tick();
      vec++; if (rd_data !== 16'd60) begin miss++; $display("FAIL t6_sweep%0d: got %0d want 60", i, rd_data); end
      vec++; if (rd_data_s !== 4'd15) begin miss++; $display("FAIL t6_ssweep%0d: got %0d want 15", i, rd_data_s); end
    end
    start = 1'b1; tick(); start = 1'b0;
    while (cyc < f1 + 59) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    vec++; if (frame_valid !== 1'b1) begin miss++; $display("FAIL t6_stop_commit: got %b want 1", frame_valid); end
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL t6_busy: got %b want 0", busy); end
    vec++; if (frame_count !== 16'd3) begin miss++; $display("FAIL t6_fc2: got %0d want 3", frame_count); end
    vec++; if (frame_overflow_s !== 1'b0) begin miss++; $display("FAIL t6_ovf_s: got %b want 0", frame_overflow_s); end
    for (int i = 0; i < MD; i++) begin
      rd_addr = 4'(i);
      tick();
      vec++; if (rd_data !== 16'(9 - i)) begin miss++; $display("FAIL t6_bin%0d: got %0d want %0d", i, rd_data, 9 - i); end
      vec++; if (rd_data_s !== 4'(9 - i)) begin miss++; $display("FAIL t6_sbin%0d: got %0d want %0d", i, rd_data_s, 9 - i); end
    end
  endtask

  initial begin
    test_reset();
    test_level_single();
    test_edge_mode();
    test_saturation();
    test_continuous_stop();
    test_async_reset();
    test_readout_during_integration();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
